cnt_seq_ctrl: RTL and testbench

Controller that sequences a 4-digit BCD event counter. It derives a count-enable tick from the system clock; no derived clocks. It runs a start/stop/clear command FSM and detects the terminal count. It also time-multiplexes the four count digits onto a single 4-bit digit bus for the 7-segment scan driver.

---
 rtl/cnt_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_cnt_seq_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_seq_ctrl.sv
// Start/stop/clear sequencer for a 4-digit BCD event counter with divided count tick,
// terminal-count detection and a time-multiplexed digit bus for a 7-segment scanner.
module cnt_seq_ctrl #(
  parameter int DIV      = 5,
  parameter int SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        up_dn,
  input  logic [15:0] limit,
  output logic [15:0] count,
  output logic        tick,
  output logic [1:0]  state,
  output logic        done,
  output logic [3:0]  scan_sel,
  output logic [3:0]  digit_out
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] DONE  = 2'b11;

  localparam int DW = $clog2(DIV);
  localparam int SW = $clog2(SCAN_DIV);

  logic [DW-1:0] div_cnt;
  logic [SW-1:0] scan_cnt;
  logic [15:0]   count_step;
  logic          terminal;

  // One BCD step of the whole count, rippling carry/borrow from digit 0 upward.
  function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic up);
    logic [15:0] r;
    logic [3:0]  d;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = v[i*4 +: 4];
      if (c) begin
        if (up) begin
          if (d == 4'd9) d = 4'd0;
          else begin d = d + 4'd1; c = 1'b0; end
        end else begin
          if (d == 4'd0) d = 4'd9;
          else begin d = d - 4'd1; c = 1'b0; end
        end
      end
      r[i*4 +: 4] = d;
    end
    return r;
  endfunction

  // A stepped count is always valid BCD, so a non-BCD limit can never match.
  always_comb begin
    count_step = bcd_step(count, up_dn);
    terminal   = up_dn ? (count_step == limit) : (count_step == 16'h0000);
  end

  assign tick = (state == RUN) && (div_cnt == DW'(DIV - 1));
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= 16'h0000;
      div_cnt <= '0;
    end else if (clear) begin
      state   <= IDLE;
      count   <= up_dn ? 16'h0000 : limit;
      div_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!stop && start) begin
            state   <= RUN;
            div_cnt <= '0;
          end
        end
        RUN: begin
          if (tick) begin
            count   <= count_step;
            div_cnt <= '0;
            if (terminal)  state <= DONE;
            else if (stop) state <= PAUSE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
            if (stop) state <= PAUSE;
          end
        end
        PAUSE: begin
          if (!stop && start) state <= RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_sel <= 4'b0001;
    end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      scan_sel <= {scan_sel[2:0], scan_sel[3]};
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    digit_out = 4'd0;
    case (scan_sel)
      4'b0001: digit_out = count[3:0];
      4'b0010: digit_out = count[7:4];
      4'b0100: digit_out = count[11:8];
      4'b1000: digit_out = count[15:12];
      default: digit_out = 4'd0;
    endcase
  end

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Directed bench for cnt_seq_ctrl: expected count steps are queued as stimulus is
// driven and retired by a monitor whenever the counter takes a step.
module tb_cnt_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, stop, clear, up_dn;
  logic [15:0] limit;
  logic [15:0] count;
  logic        tick, done;
  logic [1:0]  state;
  logic [3:0]  scan_sel, digit_out;

  logic [15:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;
  logic        step_pending = 1'b0;

  cnt_seq_ctrl #(.DIV(5), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .up_dn(up_dn), .limit(limit), .count(count), .tick(tick),
    .state(state), .done(done), .scan_sel(scan_sel), .digit_out(digit_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clear(input logic ud, input logic [15:0] lim);
    up_dn = ud;
    limit = lim;
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  // scoreboard: a step is taken on the edge ending a tick cycle unless clear/rst wins
  always @(negedge clk) begin
    if (step_pending) begin
      chk("step_queued", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) chk("step_count", {16'd0, count}, {16'd0, exp_q.pop_front()});
    end
    step_pending = tick && !clear && !rst;
  end

  initial begin
    bit   synced;
    logic [3:0] prev_sel;
    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; up_dn = 1'b1; limit = 16'h0000;
    cyc(2);
    rst = 1'b0;
    chk("rst_count", {16'd0, count}, 32'h0000);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_tick",  {31'd0, tick}, 32'd0);
    chk("rst_scan",  {28'd0, scan_sel}, 32'b0001);

    // reset in the middle of RUN
    limit = 16'h0050;
    exp_q.push_back(16'h0001); exp_q.push_back(16'h0002); exp_q.push_back(16'h0003);
    pulse_start();
    chk("run_state", {30'd0, state}, 32'd1);
    cyc(15);
    chk("pre_rst_count", {16'd0, count}, 32'h0003);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("mid_rst_count", {16'd0, count}, 32'h0000);
    chk("mid_rst_state", {30'd0, state}, 32'd0);
    chk("mid_rst_scan",  {28'd0, scan_sel}, 32'b0001);
    chk("mid_rst_tick",  {31'd0, tick}, 32'd0);

    // up count to limit 0012
    do_clear(1'b1, 16'h0012);
    chk("clr_up_count", {16'd0, count}, 32'h0000);
    foreach (exp_q[i]) ;
    for (int v = 1; v <= 9; v++) exp_q.push_back(16'(v));
    exp_q.push_back(16'h0010); exp_q.push_back(16'h0011); exp_q.push_back(16'h0012);
    pulse_start();
    cyc(3);
    chk("tick_early", {31'd0, tick}, 32'd0);
    cyc(1);
    chk("tick_first", {31'd0, tick}, 32'd1);
    cyc(1);
    chk("first_step", {16'd0, count}, 32'h0001);
    cyc(50);
    chk("up_11_count", {16'd0, count}, 32'h0011);
    chk("up_11_state", {30'd0, state}, 32'd1);
    cyc(5);
    chk("up_term_count", {16'd0, count}, 32'h0012);
    chk("up_term_state", {30'd0, state}, 32'd3);
    chk("up_term_done",  {31'd0, done}, 32'd1);
    cyc(20);
    chk("done_hold", {16'd0, count}, 32'h0012);
    start = 1'b1; stop = 1'b1;
    cyc(3);
    start = 1'b0; stop = 1'b0;
    chk("done_ignore_state", {30'd0, state}, 32'd3);
    chk("done_ignore_tick",  {31'd0, tick}, 32'd0);
    do_clear(1'b1, 16'h9999);
    chk("done_clear_state", {30'd0, state}, 32'd0);

    // up wrap 9999 -> 0000
    do_clear(1'b0, 16'h9999);
    chk("preload_9999", {16'd0, count}, 32'h9999);
    up_dn = 1'b1;
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0001);
    pulse_start();
    cyc(10);
    chk("wrap_up_count", {16'd0, count}, 32'h0001);
    chk("wrap_up_state", {30'd0, state}, 32'd1);

    // multi-digit carry 0099 -> 0100
    do_clear(1'b0, 16'h0099);
    limit = 16'h9999; up_dn = 1'b1;
    exp_q.push_back(16'h0100);
    pulse_start();
    cyc(5);
    chk("carry_count", {16'd0, count}, 32'h0100);

    // down borrow 1000 -> 0999
    do_clear(1'b0, 16'h1000);
    exp_q.push_back(16'h0999);
    pulse_start();
    cyc(5);
    chk("borrow_count", {16'd0, count}, 32'h0999);

    // down wrap 0000 -> 9999
    do_clear(1'b1, 16'h9999);
    up_dn = 1'b0;
    exp_q.push_back(16'h9999);
    pulse_start();
    cyc(5);
    chk("wrap_dn_count", {16'd0, count}, 32'h9999);
    chk("wrap_dn_state", {30'd0, state}, 32'd1);

    // down to terminal 0000
    do_clear(1'b0, 16'h0002);
    exp_q.push_back(16'h0001); exp_q.push_back(16'h0000);
    pulse_start();
    cyc(5);
    chk("dn_1_count", {16'd0, count}, 32'h0001);
    chk("dn_1_state", {30'd0, state}, 32'd1);
    cyc(5);
    chk("dn_term_count", {16'd0, count}, 32'h0000);
    chk("dn_term_done",  {31'd0, done}, 32'd1);

    // pause / resume keeps the divider phase
    do_clear(1'b1, 16'h9999);
    exp_q.push_back(16'h0001); exp_q.push_back(16'h0002);
    pulse_start();
    cyc(5);
    chk("pause_pre", {16'd0, count}, 32'h0001);
    cyc(1);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk("pause_state", {30'd0, state}, 32'd2);
    cyc(20);
    chk("pause_hold",  {16'd0, count}, 32'h0001);
    chk("pause_state2", {30'd0, state}, 32'd2);
    pulse_start();
    chk("resume_state", {30'd0, state}, 32'd1);
    cyc(2);
    chk("resume_tick", {31'd0, tick}, 32'd1);
    cyc(1);
    chk("resume_count", {16'd0, count}, 32'h0002);

    // start+stop+clear together in RUN
    start = 1'b1; stop = 1'b1; clear = 1'b1; up_dn = 1'b1;
    cyc(1);
    start = 1'b0; stop = 1'b0; clear = 1'b0;
    chk("all_cmd_state", {30'd0, state}, 32'd0);
    chk("all_cmd_count", {16'd0, count}, 32'h0000);

    // stop in the tick cycle: step taken, then PAUSE
    exp_q.push_back(16'h0001);
    pulse_start();
    cyc(4);
    chk("stop_tick_pre", {31'd0, tick}, 32'd1);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk("stop_tick_count", {16'd0, count}, 32'h0001);
    chk("stop_tick_state", {30'd0, state}, 32'd2);

    // clear in the tick cycle: no step
    pulse_start();
    cyc(4);
    chk("clr_tick_pre", {31'd0, tick}, 32'd1);
    do_clear(1'b1, 16'h0001);
    chk("clr_tick_count", {16'd0, count}, 32'h0000);
    chk("clr_tick_state", {30'd0, state}, 32'd0);

    // terminal outranks stop
    exp_q.push_back(16'h0001);
    pulse_start();
    cyc(4);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk("term_stop_state", {30'd0, state}, 32'd3);
    chk("term_stop_count", {16'd0, count}, 32'h0001);

    // display scan of 4321
    do_clear(1'b0, 16'h4321);
    chk("scan_preload", {16'd0, count}, 32'h4321);
    synced = 1'b0;
    for (int k = 0; k < 40 && !synced; k++) begin
      prev_sel = scan_sel;
      cyc(1);
      if (prev_sel == 4'b1000 && scan_sel == 4'b0001) synced = 1'b1;
    end
    chk("scan_sync", {31'd0, synced}, 32'd1);
    if (synced) begin
      for (int k = 0; k < 32; k++) begin
        chk("scan_sel",   {28'd0, scan_sel},  32'(1 << ((k / 4) % 4)));
        chk("scan_digit", {28'd0, digit_out}, 32'((k / 4) % 4 + 1));
        cyc(1);
      end
    end

    cyc(2);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
